// File: rtl/count_capture_pkg.sv
// Shared widths and constants for the count_capture timestamp path.
// No logic here; widths and reset values only.
package count_capture_pkg;

  localparam int DROP_W = 8;

  // Synchronizer resets high so a level already asserted at reset release is not an edge.
  localparam logic SYNC_RST_VAL = 1'b1;

  function automatic int ts_width(input int n, input int e);
    return n + e;
  endfunction

endpackage

// File: rtl/count_capture_ts_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head; write visible one cycle later.
// Push when full is refused unless a pop happens in the same cycle; head holds its value while empty.
module count_capture_ts_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic [W-1:0]  head_nxt;
  logic          do_wr;
  logic          do_rd;

  assign full       = (level == LW'(DEPTH));
  assign do_rd      = rd_vld & rd_rdy;
  assign do_wr      = wr_vld & (~full | do_rd);
  assign rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;
  assign level_nxt  = level + LW'(do_wr) - LW'(do_rd);

  // The incoming word becomes the head only when it lands in the next read slot.
  assign head_nxt = (do_wr && (wr_ptr == rd_ptr_nxt)) ? wr_dat : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      rd_vld <= (level_nxt != '0);
      if (level_nxt != '0) begin
        rd_dat <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/count_capture.sv
// Epoch-extends the upstream count and queues a timestamp per synchronized event edge; capture lands SYNC_STAGES+1 cycles after sampling.
// Consumer backpressure via ts_ready; captures arriving at a full FIFO with no pop are dropped and counted.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int N           = 8,
  parameter int E           = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                count_in,
  input  logic                        ovf_in,
  input  logic                        cap_en,
  input  logic                        evt_in,
  output logic [ts_width(N, E)-1:0]   ts_data,
  output logic                        ts_valid,
  input  logic                        ts_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [DROP_W-1:0]           drop_cnt
);

  localparam int TS_W = ts_width(N, E);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   evt_edge;
  logic [E-1:0]           epoch;
  logic [E-1:0]           cap_epoch;
  logic [TS_W-1:0]        cap_ts;
  logic                   cap_vld;
  logic                   fifo_full;
  logic                   fifo_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{SYNC_RST_VAL}};
      prev_q <= SYNC_RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      epoch <= '0;
    end else if (ovf_in) begin
      epoch <= epoch + E'(1);
    end
  end

  // A capture in the wrap cycle sees count 0, which already belongs to the next epoch.
  assign cap_epoch = epoch + E'(ovf_in);
  assign cap_ts    = {cap_epoch, count_in};
  assign cap_vld   = evt_edge & cap_en;
  assign fifo_pop  = ts_valid & ts_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (cap_vld && fifo_full && !fifo_pop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  count_capture_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_ts_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (cap_vld),
    .wr_dat (cap_ts),
    .rd_rdy (ts_ready),
    .rd_vld (ts_valid),
    .rd_dat (ts_data),
    .full   (fifo_full),
    .level  (fifo_level)
  );

endmodule

// File: tb/tb_count_capture.sv
// Testbench for count_capture: directed scenarios plus randomized traffic against a queue model.
module tb_count_capture;

  localparam int N     = 8;
  localparam int E     = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  count_in = '0;
  logic        ovf_in = 1'b0;
  logic        cap_en = 1'b1;
  logic        evt_in = 1'b0;
  logic        ts_ready = 1'b0;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [7:0]  m_epoch = '0;
  logic [7:0]  m_drop = '0;
  logic [15:0] m_data = '0;
  bit          hist[3] = '{1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  count_capture #(.N(N), .E(E), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .ovf_in(ovf_in), .cap_en(cap_en),
    .evt_in(evt_in), .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  // Advance one clock, updating the model from the inputs present at the edge.
  // hist[k] is the event level sampled k+1 edges ago; an edge is seen two edges after sampling.
  task automatic tick();
    bit          det;
    bit          pop;
    logic [15:0] ts;
    if (!rst) begin
      mq.delete();
      m_epoch = '0;
      m_drop  = '0;
      m_data  = '0;
      hist    = '{1'b1, 1'b1, 1'b1};
    end else begin
      det = hist[1] && !hist[2];
      ts  = {m_epoch + 8'(ovf_in), count_in};
      pop = (mq.size() > 0) && ts_ready;
      if (pop) void'(mq.pop_front());
      if (det && cap_en) begin
        if (mq.size() < DEPTH) mq.push_back(ts);
        else if (m_drop != 8'hFF) m_drop++;
      end
      m_epoch = m_epoch + 8'(ovf_in);
      if (mq.size() > 0) m_data = mq[0];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = evt_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [7:0] c, input logic o);
    evt_in = 1'b1; tick();
    evt_in = 1'b0; tick();
    count_in = c; ovf_in = o; tick();
    ovf_in = 1'b0; count_in = 8'($urandom);
  endtask

  task automatic set_epoch(input logic [7:0] v);
    while (m_epoch != v) begin
      ovf_in = 1'b1; tick();
    end
    ovf_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick();
    rst = 1'b1; evt_in = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; evt_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ts_valid, fifo_level, drop_cnt, ts_data, dut.epoch} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b lvl=%0d drop=%0d data=%h epoch=%h want all zero",
               ts_valid, fifo_level, drop_cnt, ts_data, dut.epoch);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({ts_valid, fifo_level, drop_cnt} !== 12'h0) begin
        errors++;
        $display("FAIL reset_release cyc %0d got v=%b lvl=%0d drop=%0d want 0 0 0",
                 i, ts_valid, fifo_level, drop_cnt);
      end
    end
    evt_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic_capture();
    set_epoch(8'h03);
    ts_ready = 1'b1;
    fire(8'h2A, 1'b0);
    checks++;
    if ({ts_valid, ts_data} !== {1'b1, 16'h032A}) begin
      errors++;
      $display("FAIL basic_capture got v=%b data=%h want 1 032a", ts_valid, ts_data);
    end
    tick();
    checks++;
    if ({ts_valid, fifo_level, ts_data} !== {1'b0, 3'd0, 16'h032A}) begin
      errors++;
      $display("FAIL basic_one_cycle got v=%b lvl=%0d data=%h want 0 0 032a",
               ts_valid, fifo_level, ts_data);
    end
  endtask

  task automatic test_wrap_coincident();
    set_epoch(8'h05);
    ts_ready = 1'b1;
    fire(8'hFF, 1'b0);
    checks++;
    if ({ts_valid, ts_data} !== {1'b1, 16'h05FF}) begin
      errors++;
      $display("FAIL wrap_before got v=%b data=%h want 1 05ff", ts_valid, ts_data);
    end
    tick();
    fire(8'h00, 1'b1);
    checks++;
    if ({ts_valid, ts_data, dut.epoch} !== {1'b1, 16'h0600, 8'h06}) begin
      errors++;
      $display("FAIL wrap_coincident got v=%b data=%h epoch=%h want 1 0600 06",
               ts_valid, ts_data, dut.epoch);
    end
    tick();
  endtask

  task automatic test_fifo_overflow();
    logic [15:0] exp[6];
    logic [7:0]  c;
    do_reset();
    set_epoch(8'($urandom_range(1, 40)));
    ts_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom);
      exp[i] = {m_epoch, c};
      fire(c, 1'b0);
      tick();
    end
    checks++;
    if ({ts_valid, fifo_level, drop_cnt, ts_data} !== {1'b1, 3'd4, 8'd2, exp[0]}) begin
      errors++;
      $display("FAIL overflow_full got v=%b lvl=%0d drop=%0d data=%h want 1 4 2 %h",
               ts_valid, fifo_level, drop_cnt, ts_data, exp[0]);
    end
    ts_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ts_valid, fifo_level, ts_data} !== {1'b1, 3'(4 - i), exp[i]}) begin
        errors++;
        $display("FAIL overflow_drain %0d got v=%b lvl=%0d data=%h want 1 %0d %h",
                 i, ts_valid, fifo_level, ts_data, 4 - i, exp[i]);
      end
      tick();
    end
    checks++;
    if ({ts_valid, fifo_level, ts_data} !== {1'b0, 3'd0, exp[3]}) begin
      errors++;
      $display("FAIL overflow_empty got v=%b lvl=%0d data=%h want 0 0 %h",
               ts_valid, fifo_level, ts_data, exp[3]);
    end
  endtask

  task automatic test_epoch_wrap_cap_en();
    logic [7:0] c;
    logic [7:0] d0;
    set_epoch(8'hFF);
    ovf_in = 1'b1; tick(); ovf_in = 1'b0;
    checks++;
    if (dut.epoch !== 8'h00) begin
      errors++;
      $display("FAIL epoch_wrap got %h want 00", dut.epoch);
    end
    ts_ready = 1'b1;
    c = 8'($urandom);
    fire(c, 1'b0);
    checks++;
    if ({ts_valid, ts_data} !== {1'b1, 8'h00, c}) begin
      errors++;
      $display("FAIL epoch_wrap_capture got v=%b data=%h want 1 00%h", ts_valid, ts_data, c);
    end
    tick();
    d0 = drop_cnt;
    ts_ready = 1'b0;
    cap_en = 1'b0;
    repeat (3) fire(8'($urandom), 1'b0);
    tick();
    checks++;
    if ({ts_valid, fifo_level, drop_cnt} !== {1'b0, 3'd0, d0}) begin
      errors++;
      $display("FAIL cap_en_empty got v=%b lvl=%0d drop=%0d want 0 0 %0d",
               ts_valid, fifo_level, drop_cnt, d0);
    end
    cap_en = 1'b1;
    repeat (4) fire(8'($urandom), 1'b0);
    cap_en = 1'b0;
    repeat (3) fire(8'($urandom), 1'b0);
    tick();
    checks++;
    if ({fifo_level, drop_cnt} !== {3'd4, d0}) begin
      errors++;
      $display("FAIL cap_en_full got lvl=%0d drop=%0d want 4 %0d", fifo_level, drop_cnt, d0);
    end
    cap_en = 1'b1;
    ts_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_drop_saturate();
    do_reset();
    ts_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      evt_in = 1'b1; tick();
      evt_in = 1'b0; tick();
      if (i == 100) begin
        checks++;
        if (drop_cnt !== m_drop) begin
          errors++;
          $display("FAIL drop_spacing2 got %0d want %0d", drop_cnt, m_drop);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if ({fifo_level, drop_cnt} !== {3'd4, 8'd255}) begin
      errors++;
      $display("FAIL drop_saturate got lvl=%0d drop=%0d want 4 255", fifo_level, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_epoch(8'($urandom_range(1, 50)));
    ts_ready = 1'b0;
    repeat (9) fire(8'($urandom), 1'b0);
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    checks++;
    if ({ts_valid, fifo_level, drop_cnt} !== {1'b1, 3'd3, 8'd5}) begin
      errors++;
      $display("FAIL reset_mid_setup got v=%b lvl=%0d drop=%0d want 1 3 5",
               ts_valid, fifo_level, drop_cnt);
    end
    rst = 1'b0; evt_in = 1'b1; ovf_in = 1'b1; ts_ready = 1'b1;
    tick();
    rst = 1'b1; evt_in = 1'b0; ovf_in = 1'b0; ts_ready = 1'b0;
    checks++;
    if ({ts_valid, fifo_level, drop_cnt, dut.epoch} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%b lvl=%0d drop=%0d epoch=%h want 0 0 0 00",
               ts_valid, fifo_level, drop_cnt, dut.epoch);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 249) != 0);
      evt_in   = ($urandom_range(0, 2) == 0);
      count_in = 8'($urandom);
      ovf_in   = ($urandom_range(0, 15) == 0);
      cap_en   = ($urandom_range(0, 7) != 0);
      ts_ready = (i % 400 < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if ({ts_valid, fifo_level, drop_cnt, ts_data, dut.epoch} !==
          {mq.size() != 0, 3'(mq.size()), m_drop, m_data, m_epoch}) begin
        errors++;
        $display("FAIL random cyc %0d got v=%b lvl=%0d drop=%0d data=%h ep=%h want v=%b lvl=%0d drop=%0d data=%h ep=%h",
                 i, ts_valid, fifo_level, drop_cnt, ts_data, dut.epoch,
                 mq.size() != 0, mq.size(), m_drop, m_data, m_epoch);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_wrap_coincident();
    test_fifo_overflow();
    test_epoch_wrap_cap_en();
    test_drop_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Sits directly downstream of the free-running N-bit event counter.
- Consumes the counter's count value and its one-cycle overflow pulse, and extends the count with an E-bit epoch register into an (N+E)-bit timestamp.
- On each rising edge of an asynchronous external event, captures the timestamp into a small FIFO.
- Delivers captured timestamps to the consumer over a valid/ready handshake.

Parameters:
- N, 8, width of the upstream count value.
- E, 8, width of the epoch (overflow) extension.
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- SYNC_STAGES, 2, event synchronizer flops (≥2).

Ports:
- clk  in  1  rising-edge clock, shared with the upstream counter.
- rst  in  1  reset: synchronous, active-low.
- count_in  in  N  registered count from the upstream counter.
- ovf_in  in  1  one-cycle pulse, high in the cycle count_in shows the wrapped value.
- cap_en  in  1  capture enable. Edges are ignored while low.
- evt_in  in  1  asynchronous external event.
- ts_data  out  N+E  {epoch, count} of the head FIFO entry.
- ts_valid  out  1  head entry valid.
- ts_ready  in  1  consumer accepts the head entry.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  8  events lost to a full FIFO; saturating.

Behaviour:
- Reset (rst==0 at a clk edge):
  - epoch=0, FIFO emptied, fifo_level=0, ts_valid=0, ts_data=0, drop_cnt=0.
  - Synchronizer chain forced to all-ones, so evt_in held high across reset release produces no event.
- Reset mid-operation: all queued entries are discarded, with no partial handshake. Reset wins over every simultaneous event.
- Epoch:
  - If ovf_in==1 in cycle t, epoch becomes epoch+1 (mod 2^E) in cycle t+1.
  - No other source modifies epoch.
- Edge detect:
  - evt_in passes through SYNC_STAGES flops; edge = newest_sync & ~prev_sync.
  - A rise sampled at edge k gives edge high in cycle k+SYNC_STAGES (the detect cycle).
  - Minimum resolvable event spacing is 2 cycles. Narrower pulses may be lost, which is acceptable.
- Capture, in the detect cycle with cap_en==1:
  - Timestamp = {epoch + ovf_in, count_in}.
  - The +ovf_in term keeps a capture coincident with wrap coherent: count 0 belongs to the new epoch.
  - E-bit addition wraps.
- cap_en==0: the edge is discarded; drop_cnt is unchanged.
- FIFO: first-word fall-through.
  - An entry written in cycle t appears as ts_valid=1 with its ts_data in cycle t+1.
  - Entries are delivered in capture order.
- Handshake:
  - Pop occurs when ts_valid & ts_ready.
  - ts_data is stable while ts_valid & ~ts_ready.
  - ts_valid never drops without a pop.
- Full (level==DEPTH):
  - Capture without a pop: the entry is dropped and drop_cnt increments, saturating at 255.
  - Capture with a simultaneous pop: the write is accepted and the level stays DEPTH.
- Empty: ts_valid=0, ts_ready is ignored, and ts_data holds its last value.
- Push and pop in the same cycle with 0<level<DEPTH: level is unchanged.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - Timestamp width function (N+E).
  - Drop counter width constant (8).
  - Synchronizer reset-value constant.
- One natural sub-module: ts_fifo.
  - Parameterized width/depth synchronous FWFT FIFO with push/pop/full/empty/level.
  - Reusable elsewhere in the timer path.
- Synchronizer, edge detect, epoch and drop counter stay in the top level.

Test Plan (N=8, E=8, DEPTH=4, SYNC_STAGES=2 throughout):
- Reset hold: rst=0 for 3 cycles with evt_in=1, then release with evt_in held 1 -> ts_valid stays 0, fifo_level=0, drop_cnt=0, epoch=0.
- Basic capture: epoch=0x03, evt_in rises sampled at edge k, count_in=0x2A in cycle k+2, ts_ready=1 -> ts_valid=1 with ts_data=0x032A in cycle k+3 for exactly one cycle.
- Wrap-coincident: epoch=0x05, detect cycle has ovf_in=1 and count_in=0x00 -> ts_data=0x0600; epoch reads 0x06 afterwards. Capture one cycle before, count_in=0xFF -> 0x05FF.
- Overflow of FIFO: ts_ready=0, six events spaced 4 cycles apart -> fifo_level=4, drop_cnt=2. Then ts_ready=1 -> the first four timestamps pop in order on consecutive cycles and fifo_level reaches 0.
- Epoch wrap and cap_en: epoch=0xFF, ovf pulse -> epoch=0x00 and the next capture reads 0x00xx. With cap_en=0, three events -> no entries and drop_cnt unchanged.
- Reset mid-operation: fifo_level=3, ts_valid=1, drop_cnt=5, then rst=0 for one cycle -> next cycle fifo_level=0, ts_valid=0, drop_cnt=0, epoch=0.
